// File: rtl/anc_pkg.sv
// Shared definitions for the multi-channel adaptive LMS noise canceller.
// Contents:
//   ANC_ADAPT/ANC_FREEZE/ANC_BYPASS/ANC_CLEAR : per-frame mode encodings
//   anc_state_e                               : controller state enum
//   saturate()                                : clip a signed value to out_w bits
package anc_pkg;

  localparam logic [1:0] ANC_ADAPT  = 2'b00;
  localparam logic [1:0] ANC_FREEZE = 2'b01;
  localparam logic [1:0] ANC_BYPASS = 2'b10;
  localparam logic [1:0] ANC_CLEAR  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StDone,
    StClear
  } anc_state_e;

  // Working width of saturate(): callers sign-extend their value (of any in-width
  // up to SatW) into it and take the low out_w bits of the result.
  localparam int unsigned SatW = 64;

  function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] val,
                                                      input int unsigned            out_w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = ~hi;
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/anc_mac_lane.sv
// One-tap LMS datapath, shared by every channel and tap of anc_lms_mc.
// Ports:
//   w       : current (pre-update) weight, Q(WW-WFRAC).WFRAC
//   x_cur   : x[n-k], multiplies the weight into the accumulator
//   x_prev  : x[n-1-k], drives the weight update
//   delta   : mu*e for the channel, Q1.15
//   acc_in  : running accumulator of the channel
//   adapt   : 1 = apply the weight update, 0 = pass w through
//   acc_out : acc_in + w*x_cur
//   w_next  : weight to write back
//   w_clip  : the weight update saturated
module anc_mac_lane
  import anc_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned WW    = 26,
  parameter int unsigned WFRAC = 24,
  parameter int unsigned AccW  = 49
) (
  input  logic signed [WW-1:0]   w,
  input  logic signed [DW-1:0]   x_cur,
  input  logic signed [DW-1:0]   x_prev,
  input  logic signed [DW-1:0]   delta,
  input  logic signed [AccW-1:0] acc_in,
  input  logic                   adapt,
  output logic signed [AccW-1:0] acc_out,
  output logic signed [WW-1:0]   w_next,
  output logic                   w_clip
);

  localparam int unsigned PW     = DW + WW;
  localparam int unsigned UW     = 2 * DW;
  // delta*x is Q2.30; shift it down to the weight's fractional alignment.
  localparam int unsigned WShift = 30 - WFRAC;

  logic signed [PW-1:0]   prod;
  logic signed [UW-1:0]   upd_full;
  logic signed [UW-1:0]   upd;
  logic signed [SatW-1:0] w_sum;
  logic signed [SatW-1:0] w_sat;

  always_comb begin
    prod     = PW'(w) * PW'(x_cur);
    acc_out  = acc_in + AccW'(prod);
    upd_full = UW'(delta) * UW'(x_prev);
    upd      = upd_full >>> WShift;
    w_sum    = SatW'(w) + SatW'(upd);
    w_sat    = saturate(w_sum, WW);
    w_clip   = adapt && (w_sat != w_sum);
    w_next   = adapt ? w_sat[WW-1:0] : w;
  end

endmodule

// File: rtl/anc_lms_mc.sv
// Multi-channel adaptive LMS FIR noise canceller. CH independent filters of TAPS
// taps share one time-multiplexed MAC lane; each accepted frame pushes one x per
// channel, filters every channel and (in adapt mode) updates the weights in the
// same tap pass.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : sample frame valid; in_ready: block idle and accepting
//   mode        : 00 adapt, 01 freeze, 10 bypass, 11 clear (latched on accept)
//   x_in, e_in  : reference / error samples per channel, ch0 in LSBs, Q1.15
//   mu_in       : shared step size, Q1.15
//   out_sample  : filter outputs per channel, ch0 in LSBs, held between frames
//   out_valid   : one-cycle pulse when out_sample is updated
//   busy        : controller not idle
//   sat_flag    : sticky, an output or weight was clipped (cleared by rst/clear)
module anc_lms_mc
  import anc_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned WW    = 26,
  parameter int unsigned WFRAC = 24,
  parameter int unsigned TAPS  = 64,
  parameter int unsigned CH    = 2,
  parameter int unsigned AW    = $clog2(TAPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [CH*DW-1:0]   x_in,
  input  logic [CH*DW-1:0]   e_in,
  input  logic [DW-1:0]      mu_in,
  output logic [CH*DW-1:0]   out_sample,
  output logic               out_valid,
  output logic               busy,
  output logic               sat_flag
);

  localparam int unsigned AccW = DW + WW + AW;
  localparam int unsigned TW   = $clog2(TAPS);
  localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned PW2  = 2 * DW;

  localparam logic [AW-1:0] LastPos = AW'(TAPS);
  localparam logic [TW-1:0] LastTap = TW'(TAPS - 1);
  localparam logic [CW-1:0] LastCh  = CW'(CH - 1);

  anc_state_e state_q, state_d;

  logic [1:0]             mode_q;
  logic signed [DW-1:0]   mu_q;
  logic signed [DW-1:0]   x_q     [CH];
  logic signed [DW-1:0]   e_q     [CH];
  logic signed [DW-1:0]   delta_q [CH];
  logic signed [DW-1:0]   hist_q  [CH][TAPS+1];
  logic signed [WW-1:0]   w_q     [CH][TAPS];
  logic signed [AccW-1:0] acc_q   [CH];

  // head_q: next history slot to write; wpos_q: slot holding x[n] of this frame;
  // cur_ptr_q walks backwards from wpos_q, one slot per tap.
  logic [AW-1:0] head_q;
  logic [AW-1:0] wpos_q;
  logic [AW-1:0] cur_ptr_q;
  logic [AW-1:0] prev_ptr;
  logic [TW-1:0] tap_q;
  logic [CW-1:0] ch_q;

  logic [CH*DW-1:0] out_q;
  logic             sat_q;

  logic                   calc_last;
  logic signed [PW2-1:0]  mu_e [CH];
  logic signed [AccW-1:0] lane_acc;
  logic signed [WW-1:0]   lane_w_next;
  logic                   lane_w_clip;

  logic [CH*DW-1:0]       out_d;
  logic                   out_clip;
  logic signed [AccW-1:0] acc_fin;
  logic signed [SatW-1:0] out_pre;
  logic signed [SatW-1:0] out_sat;

  assign calc_last = (tap_q == LastTap) && (ch_q == LastCh);
  assign prev_ptr  = (cur_ptr_q == '0) ? LastPos : cur_ptr_q - 1'b1;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          case (mode)
            ANC_CLEAR:  state_d = StClear;
            ANC_BYPASS: state_d = StDone;
            default:    state_d = StLoad;
          endcase
        end
      end
      StLoad:  state_d = StCalc;
      StCalc:  if (calc_last) state_d = StDone;
      StDone:  state_d = StIdle;
      StClear: if (tap_q == LastTap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    out_valid  = (state_q == StDone);
    out_sample = out_q;
    sat_flag   = sat_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  anc_mac_lane #(
    .DW    (DW),
    .WW    (WW),
    .WFRAC (WFRAC),
    .AccW  (AccW)
  ) u_lane (
    .w       (w_q[ch_q][tap_q]),
    .x_cur   (hist_q[ch_q][cur_ptr_q]),
    .x_prev  (hist_q[ch_q][prev_ptr]),
    .delta   (delta_q[ch_q]),
    .acc_in  (acc_q[ch_q]),
    .adapt   (mode_q == ANC_ADAPT),
    .acc_out (lane_acc),
    .w_next  (lane_w_next),
    .w_clip  (lane_w_clip)
  );

  always_comb begin
    for (int c = 0; c < int'(CH); c++) begin
      mu_e[c] = PW2'(mu_q) * PW2'(e_q[c]);
    end
  end

  // Final outputs, used on the last CALC cycle: the last channel's accumulator
  // is still being completed by the lane, the others are already settled.
  always_comb begin
    out_d    = '0;
    out_clip = 1'b0;
    acc_fin  = '0;
    out_pre  = '0;
    out_sat  = '0;
    for (int c = 0; c < int'(CH); c++) begin
      acc_fin = (c == int'(CH) - 1) ? lane_acc : acc_q[c];
      out_pre = SatW'(acc_fin >>> WFRAC);
      out_sat = saturate(out_pre, DW);
      out_d[c*DW +: DW] = out_sat[DW-1:0];
      if (out_sat != out_pre) out_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= ANC_ADAPT;
      mu_q      <= '0;
      head_q    <= '0;
      wpos_q    <= '0;
      cur_ptr_q <= '0;
      tap_q     <= '0;
      ch_q      <= '0;
      out_q     <= '0;
      sat_q     <= 1'b0;
      for (int c = 0; c < int'(CH); c++) begin
        x_q[c]     <= '0;
        e_q[c]     <= '0;
        delta_q[c] <= '0;
        acc_q[c]   <= '0;
        for (int k = 0; k <= int'(TAPS); k++) hist_q[c][k] <= '0;
        for (int k = 0; k < int'(TAPS); k++) w_q[c][k] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mode_q <= mode;
            mu_q   <= mu_in;
            tap_q  <= '0;
            ch_q   <= '0;
            for (int c = 0; c < int'(CH); c++) begin
              x_q[c] <= x_in[c*DW +: DW];
              e_q[c] <= e_in[c*DW +: DW];
            end
            if (mode == ANC_BYPASS) out_q <= x_in;
          end
        end

        StLoad: begin
          for (int c = 0; c < int'(CH); c++) begin
            hist_q[c][head_q] <= x_q[c];
            delta_q[c]        <= DW'(saturate(SatW'(mu_e[c] >>> (DW - 1)), DW));
            acc_q[c]          <= '0;
          end
          head_q    <= (head_q == LastPos) ? '0 : head_q + 1'b1;
          wpos_q    <= head_q;
          cur_ptr_q <= head_q;
          tap_q     <= '0;
          ch_q      <= '0;
        end

        StCalc: begin
          acc_q[ch_q]        <= lane_acc;
          w_q[ch_q][tap_q]   <= lane_w_next;
          if (lane_w_clip) sat_q <= 1'b1;
          if (tap_q == LastTap) begin
            tap_q     <= '0;
            cur_ptr_q <= wpos_q;
            if (ch_q == LastCh) begin
              ch_q  <= '0;
              out_q <= out_d;
              if (out_clip) sat_q <= 1'b1;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else begin
            tap_q     <= tap_q + 1'b1;
            cur_ptr_q <= prev_ptr;
          end
        end

        StClear: begin
          for (int c = 0; c < int'(CH); c++) w_q[c][tap_q] <= '0;
          sat_q <= 1'b0;
          tap_q <= tap_q + 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule
